// File: rtl/roll_decimator_if.sv
// Sample-stream bundle between the acquisition path and the roll decimator:
// window control, sample input and the reduced display sample output.
interface roll_decimator_if #(
  parameter int DATA_W  = 12,
  parameter int SHIFT_W = 4
);
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [SHIFT_W-1:0] shift;
  logic [1:0]        mode;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  // Producer side: drives samples and configuration, observes output.
  modport master (
    output clear, in_valid, in_data, shift, mode,
    input  out_valid, out_data
  );

  // Decimator side.
  modport slave (
    input  clear, in_valid, in_data, shift, mode,
    output out_valid, out_data
  );
endinterface

// File: rtl/roll_decimator.sv
// Roll-mode decimator: reduces every 2^shift accepted samples to one display
// sample by averaging, peak-max, peak-min or plain decimation.
module roll_decimator #(
  parameter int DATA_W    = 12,
  parameter int SHIFT_MAX = 15,
  parameter int SHIFT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  roll_decimator_if.slave  bus
);
  // Wide enough that a full 2^SHIFT_MAX window of full-scale samples fits.
  localparam int ACC_W = DATA_W + SHIFT_MAX;

  logic [SHIFT_MAX-1:0] cnt;
  logic [ACC_W-1:0]     acc;
  logic [DATA_W-1:0]    pk_max;
  logic [DATA_W-1:0]    pk_min;
  logic [SHIFT_W-1:0]   shift_q;
  logic [1:0]           mode_q;

  logic [SHIFT_W-1:0]   shift_c;
  logic                 cfg_change;
  logic [SHIFT_W-1:0]   eff_shift;
  logic [1:0]           eff_mode;
  logic [SHIFT_MAX-1:0] eff_cnt;
  logic [ACC_W-1:0]     eff_acc;
  logic [DATA_W-1:0]    eff_max;
  logic [DATA_W-1:0]    eff_min;
  logic [SHIFT_MAX-1:0] win_mask;
  logic                 is_last;
  logic [ACC_W-1:0]     acc_sum;
  logic [DATA_W-1:0]    new_max;
  logic [DATA_W-1:0]    new_min;
  logic [DATA_W-1:0]    cand;

  // Clamp the requested ratio and detect a configuration change this cycle.
  always_comb begin
    shift_c    = (bus.shift > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : bus.shift;
    cfg_change = (shift_c != shift_q) || (bus.mode != mode_q);
  end

  // On a configuration change the incoming sample opens a fresh window under
  // the new settings, so evaluate it against a restarted state; the same
  // datapath then serves both the normal and the reconfigured case.
  always_comb begin
    eff_shift = cfg_change ? shift_c  : shift_q;
    eff_mode  = cfg_change ? bus.mode : mode_q;
    eff_cnt   = cfg_change ? '0       : cnt;
    eff_acc   = cfg_change ? '0       : acc;
    eff_max   = cfg_change ? '0       : pk_max;
    eff_min   = cfg_change ? '1       : pk_min;
    win_mask  = ~({SHIFT_MAX{1'b1}} << eff_shift);
    is_last   = (eff_cnt == win_mask);
    acc_sum   = eff_acc + ACC_W'(bus.in_data);
    new_max   = (bus.in_data > eff_max) ? bus.in_data : eff_max;
    new_min   = (bus.in_data < eff_min) ? bus.in_data : eff_min;
    case (eff_mode)
      2'b00:   cand = DATA_W'(acc_sum >> eff_shift);
      2'b01:   cand = new_max;
      2'b10:   cand = new_min;
      default: cand = bus.in_data;
    endcase
  end

  // Window state, configuration registers and the registered output strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      acc           <= '0;
      pk_max        <= '0;
      pk_min        <= '1;
      shift_q       <= '0;
      mode_q        <= 2'b00;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.clear) begin
        // Drop the partial window and any sample arriving with the clear.
        cnt    <= '0;
        acc    <= '0;
        pk_max <= '0;
        pk_min <= '1;
      end else begin
        if (cfg_change) begin
          shift_q <= shift_c;
          mode_q  <= bus.mode;
          cnt     <= '0;
          acc     <= '0;
          pk_max  <= '0;
          pk_min  <= '1;
        end
        if (bus.in_valid) begin
          if (is_last) begin
            bus.out_data  <= cand;
            bus.out_valid <= 1'b1;
            cnt           <= '0;
            acc           <= '0;
            pk_max        <= '0;
            pk_min        <= '1;
          end else begin
            cnt    <= eff_cnt + 1'b1;
            acc    <= acc_sum;
            pk_max <= new_max;
            pk_min <= new_min;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_roll_decimator.sv
// Directed bench for roll_decimator: the driver pushes hand-computed expected
// strobes into a queue, a monitor pops and checks them when out_valid is seen.
module tb_roll_decimator;
  logic clk;
  logic rst_n;

  roll_decimator_if #(.DATA_W(12), .SHIFT_W(4)) bus ();

  roll_decimator #(.DATA_W(12), .SHIFT_MAX(15), .SHIFT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int    data;
    int    cyc;
    string name;
  } exp_t;

  exp_t       q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [3:0] cur_shift = 4'd0;
  logic [1:0] cur_mode  = 2'd0;
  int         win_a[8] = '{5, 900, 3, 7, 7, 7, 7, 7};
  int         win_b[8] = '{10, 11, 12, 13, 14, 15, 16, 17};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index, used to verify the one-cycle output latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int d, input logic clr);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = 12'(d);
    bus.clear    = clr;
    bus.shift    = cur_shift;
    bus.mode     = cur_mode;
  endtask

  // Call right after driving the last sample of a window.
  task automatic push_exp(input string nm, input int val);
    exp_t e;
    e.data = val;
    e.cyc  = cyc + 1;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic send_win(input logic [1:0] md, input int sel, input string nm, input int exp);
    cur_mode = md;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (sel == 0) ? win_a[i] : win_b[i], 1'b0);
      if (i == 7) push_exp(nm, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: got out_data=%0d at cycle %0d, required no strobe",
                 bus.out_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("strobe %s: out_data=%0d cycle=%0d (want %0d at %0d)",
                 e.name, bus.out_data, cyc, e.data, e.cyc);
        check(e.name, int'(bus.out_data), e.data);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clear    = 1'b0;
    bus.shift    = '0;
    bus.mode     = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: pass-through at N=1 on consecutive cycles.
    cur_shift = 4'd0;
    cur_mode  = 2'd0;
    drive(1'b1, 'h123, 1'b0);
    push_exp("pass_0", 'h123);
    drive(1'b1, 'hABC, 1'b0);
    push_exp("pass_1", 'hABC);
    idle(3);
    @(negedge clk);
    check("hold_out_data", int'(bus.out_data), 'hABC);

    // 2: average over 4 with in_valid gaps: 101 >> 2 = 25.
    cur_shift = 4'd2;
    idle(1);
    drive(1'b1, 10, 1'b0);
    idle(1);
    drive(1'b1, 20, 1'b0);
    idle(2);
    drive(1'b1, 30, 1'b0);
    idle(1);
    drive(1'b1, 41, 1'b0);
    push_exp("avg4", 25);
    idle(3);

    // 3: largest window of full-scale samples, then the clamp-range code.
    cur_shift = 4'd15;
    idle(1);
    for (int i = 0; i < 32768; i++) begin
      drive(1'b1, 'hFFF, 1'b0);
      if (i == 32767) push_exp("avg32768", 'hFFF);
    end
    idle(2);
    cur_shift = 4'hF;
    for (int i = 0; i < 32768; i++) begin
      drive(1'b1, 'hFFF, 1'b0);
      if (i == 32767) push_exp("avg32768_clamp", 'hFFF);
    end
    idle(2);

    // 4: peak/decimate modes, windows back-to-back without idle cycles.
    cur_shift = 4'd3;
    cur_mode  = 2'd1;
    idle(1);
    send_win(2'd1, 0, "max_a", 900);
    send_win(2'd1, 1, "max_b", 17);
    send_win(2'd2, 0, "min_a", 3);
    send_win(2'd2, 1, "min_b", 10);
    send_win(2'd3, 0, "dec_a", 7);
    send_win(2'd3, 1, "dec_b", 17);
    send_win(2'd0, 0, "avg8_a", 117);
    idle(2);

    // 5: ratio change mid-window; sample 8 opens the new window: (8+4)>>1 = 6.
    cur_mode  = 2'd0;
    cur_shift = 4'd2;
    idle(1);
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 200, 1'b0);
    cur_shift = 4'd1;
    drive(1'b1, 8, 1'b0);
    drive(1'b1, 4, 1'b0);
    push_exp("reconfig", 6);
    idle(3);

    // 6a: clear mid-window discards the partial window and its own sample.
    cur_shift = 4'd2;
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b1, 7, 1'b0);
    drive(1'b1, 4000, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 100, 1'b0);
    push_exp("after_clear", 100);
    // A clear in the strobe cycle leaves the pending strobe intact.
    drive(1'b1, 55, 1'b1);
    idle(2);

    // 6b: the same with a reset pulse in place of clear.
    for (int i = 0; i < 3; i++) drive(1'b1, 7, 1'b0);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_out_valid", int'(bus.out_valid), 0);
    check("rst_mid_out_data", int'(bus.out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 100, 1'b0);
    push_exp("after_reset", 100);
    idle(5);

    check("pending_expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
